// File: rtl/registro_etapa_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : registro_etapa_pipe
//  Purpose  : Parametrised pipeline stage register. It carries an instruction
//             word and a flat control bundle between two pipeline stages. It
//             provides a valid/ready handshake, a 2-entry skid buffer, a
//             hazard stall and a flush that inserts a bubble.
//  Ports    : clk, rst_n             - clock, asynchronous active-low reset
//             in_valid/in_ready      - upstream handshake
//             instr_in, ctrl_in      - incoming payload
//             stall                  - holds the output side (no out transfer)
//             flush                  - kills every held word, drops input
//             out_valid/out_ready    - downstream handshake
//             instr_out, ctrl_out    - presented payload (masked when empty)
//             occupancy              - held words: 0, 1 or 2
//  Options  : NEGEDGE_OUT_EN - re-time out_valid/instr_out/ctrl_out through
//             a negative-edge register (legacy half-cycle release).
//  Revision : 1.0 - initial release
// ============================================================================
module registro_etapa_pipe #(
    parameter int                 INSTR_W   = 14,
    parameter int                 CTRL_W    = 17,
    parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic [CTRL_W-1:0]  ctrl_in,
    input  logic               stall,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] instr_out,
    output logic [CTRL_W-1:0]  ctrl_out,
    output logic [1:0]         occupancy
);

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [INSTR_W-1:0]   main_instr_q, main_instr_d;
    logic [CTRL_W-1:0]    main_ctrl_q,  main_ctrl_d;
    logic [INSTR_W-1:0]   skid_instr_q, skid_instr_d;
    logic [CTRL_W-1:0]    skid_ctrl_q,  skid_ctrl_d;
    logic                 in_ready_q;

    logic                 main_valid;
    logic                 in_fire;
    logic                 out_fire;

    assign main_valid = (state_q != EMPTY);
    assign in_fire    = in_valid & in_ready_q;
    assign out_fire   = main_valid & out_ready & ~stall;

    always_comb begin
        state_d      = state_q;
        main_instr_d = main_instr_q;
        main_ctrl_d  = main_ctrl_q;
        skid_instr_d = skid_instr_q;
        skid_ctrl_d  = skid_ctrl_q;
        unique case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d      = ONE;
                    main_instr_d = instr_in;
                    main_ctrl_d  = ctrl_in;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    main_instr_d = instr_in;
                    main_ctrl_d  = ctrl_in;
                end else if (in_fire) begin
                    // Downstream did not take the main word: park the new
                    // one in the skid entry.
                    state_d      = FULL;
                    skid_instr_d = instr_in;
                    skid_ctrl_d  = ctrl_in;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                // in_ready is low here, so only the drain case exists.
                if (out_fire) begin
                    state_d      = ONE;
                    main_instr_d = skid_instr_q;
                    main_ctrl_d  = skid_ctrl_q;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Flush overrides everything, including a simultaneous accept.
        if (flush) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= EMPTY;
            main_instr_q <= NOP_INSTR;
            main_ctrl_q  <= '0;
            skid_instr_q <= NOP_INSTR;
            skid_ctrl_q  <= '0;
            in_ready_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            main_instr_q <= main_instr_d;
            main_ctrl_q  <= main_ctrl_d;
            skid_instr_q <= skid_instr_d;
            skid_ctrl_q  <= skid_ctrl_d;
            // Registered from next state so out_ready/stall never reach
            // in_ready combinationally.
            in_ready_q   <= (state_d != FULL);
        end
    end

    // Bubble masking: an empty stage presents NOP and an all-zero control
    // bundle so no write enable can leak downstream.
    logic [INSTR_W-1:0] main_instr_masked;
    logic [CTRL_W-1:0]  main_ctrl_masked;

    assign main_instr_masked = main_valid ? main_instr_q : NOP_INSTR;
    assign main_ctrl_masked  = main_valid ? main_ctrl_q  : '0;

    assign in_ready  = in_ready_q;
    assign occupancy = state_q;

`ifdef NEGEDGE_OUT_EN
    logic               out_valid_nq;
    logic [INSTR_W-1:0] instr_out_nq;
    logic [CTRL_W-1:0]  ctrl_out_nq;

    // Half-cycle release: the main entry becomes visible at the falling
    // edge; at every rising edge it already equals the internal state.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_nq <= 1'b0;
            instr_out_nq <= NOP_INSTR;
            ctrl_out_nq  <= '0;
        end else begin
            out_valid_nq <= main_valid;
            instr_out_nq <= main_instr_masked;
            ctrl_out_nq  <= main_ctrl_masked;
        end
    end

    assign out_valid = out_valid_nq;
    assign instr_out = instr_out_nq;
    assign ctrl_out  = ctrl_out_nq;
`else
    assign out_valid = main_valid;
    assign instr_out = main_instr_masked;
    assign ctrl_out  = main_ctrl_masked;
`endif

endmodule
`default_nettype wire

// File: tb/tb_registro_etapa_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_registro_etapa_pipe
//  Purpose  : Self-checking bench for registro_etapa_pipe. A queue model of
//             the held words predicts all outputs; directed vectors add
//             hand-computed literal expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_registro_etapa_pipe;

    localparam int INSTR_W = 14;
    localparam int CTRL_W  = 17;

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [INSTR_W-1:0] instr_in = '0;
    logic [CTRL_W-1:0]  ctrl_in = '0;
    logic               stall = 1'b0;
    logic               flush = 1'b0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [INSTR_W-1:0] instr_out;
    logic [CTRL_W-1:0]  ctrl_out;
    logic [1:0]         occupancy;

    int checks = 0;
    int errors = 0;

    registro_etapa_pipe #(
        .INSTR_W   (INSTR_W),
        .CTRL_W    (CTRL_W),
        .NOP_INSTR ('0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr_in  (instr_in),
        .ctrl_in   (ctrl_in),
        .stall     (stall),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .instr_out (instr_out),
        .ctrl_out  (ctrl_out),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;   // rising edges at 5, 15, 25, ...

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model: FIFO of held words, capacity 2 ----------------
    logic [INSTR_W+CTRL_W-1:0] mq[$];

    always @(posedge clk) begin
        logic m_in_fire;
        logic m_out_fire;
        if (rst_n) begin
            m_in_fire  = in_valid && (mq.size() < 2);
            m_out_fire = (mq.size() > 0) && out_ready && !stall;
            if (flush) begin
                mq.delete();
            end else begin
                if (m_out_fire) void'(mq.pop_front());
                if (m_in_fire)  mq.push_back({instr_in, ctrl_in});
            end
        end
    end

    always @(negedge rst_n) mq.delete();

    // ---------------- per-cycle compare, just before each rising edge ------
    initial begin
        forever begin
            @(posedge clk);
            #9;
            if (rst_n) begin
                chk("m_out_valid", {31'd0, out_valid}, {31'd0, mq.size() > 0});
                chk("m_in_ready",  {31'd0, in_ready},  {31'd0, mq.size() < 2});
                chk("m_occupancy", {30'd0, occupancy}, mq.size());
                if (mq.size() > 0) begin
                    chk("m_instr_out", {18'd0, instr_out}, {18'd0, mq[0][INSTR_W+CTRL_W-1:CTRL_W]});
                    chk("m_ctrl_out",  {15'd0, ctrl_out},  {15'd0, mq[0][CTRL_W-1:0]});
                end else begin
                    chk("m_instr_nop", {18'd0, instr_out}, 32'd0);
                    chk("m_ctrl_zero", {15'd0, ctrl_out},  32'd0);
                end
            end
        end
    end

    // Drive inputs two time units before a rising edge, then return two
    // units before the next one so results of that edge are visible.
    task automatic cyc(input logic v, input logic [INSTR_W-1:0] ins, input logic [CTRL_W-1:0] c,
                       input logic ordy, input logic stl, input logic fl);
        in_valid  = v;
        instr_in  = ins;
        ctrl_in   = c;
        out_ready = ordy;
        stall     = stl;
        flush     = fl;
        @(posedge clk);
        #8;
    endtask

    task automatic lit(input string tag, input logic v, input logic [INSTR_W-1:0] ins,
                       input logic [CTRL_W-1:0] c, input logic [1:0] occ, input logic rdy);
        chk({tag, "_valid"}, {31'd0, out_valid}, {31'd0, v});
        chk({tag, "_instr"}, {18'd0, instr_out}, {18'd0, ins});
        chk({tag, "_ctrl"},  {15'd0, ctrl_out},  {15'd0, c});
        chk({tag, "_occ"},   {30'd0, occupancy}, {30'd0, occ});
        chk({tag, "_ready"}, {31'd0, in_ready},  {31'd0, rdy});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values while reset is held.
        #1 rst_n = 1'b0;
        #1 lit("reset", 1'b0, 14'h0000, 17'h00000, 2'd0, 1'b1);
        #1 rst_n = 1'b1;   // t=3, two units before the first rising edge

        // Streaming: one word per cycle, occupancy stays 1.
        for (int i = 1; i <= 5; i++) begin
            cyc(1'b1, 14'(i), 17'(32'h100 + i), 1'b1, 1'b0, 1'b0);
            lit("stream", 1'b1, 14'(i), 17'(32'h100 + i), 2'd1, 1'b1);
        end
        cyc(1'b0, 14'h0, 17'h0, 1'b1, 1'b0, 1'b0);
        lit("stream_drain", 1'b0, 14'h0000, 17'h00000, 2'd0, 1'b1);

        // Back-pressure: two accepts fill the stage, the third word waits.
        cyc(1'b1, 14'h00A1, 17'h000A1, 1'b0, 1'b0, 1'b0);
        lit("bp1", 1'b1, 14'h00A1, 17'h000A1, 2'd1, 1'b1);
        cyc(1'b1, 14'h00A2, 17'h000A2, 1'b0, 1'b0, 1'b0);
        lit("bp2", 1'b1, 14'h00A1, 17'h000A1, 2'd2, 1'b0);
        cyc(1'b1, 14'h00A3, 17'h000A3, 1'b0, 1'b0, 1'b0);
        lit("bp3", 1'b1, 14'h00A1, 17'h000A1, 2'd2, 1'b0);
        cyc(1'b1, 14'h00A3, 17'h000A3, 1'b1, 1'b0, 1'b0);
        lit("bp4", 1'b1, 14'h00A2, 17'h000A2, 2'd1, 1'b1);
        cyc(1'b1, 14'h00A3, 17'h000A3, 1'b1, 1'b0, 1'b0);
        lit("bp5", 1'b1, 14'h00A3, 17'h000A3, 2'd1, 1'b1);
        cyc(1'b0, 14'h0, 17'h0, 1'b1, 1'b0, 1'b0);
        lit("bp_drain", 1'b0, 14'h0000, 17'h00000, 2'd0, 1'b1);

        // Stall with out_ready high holds the word.
        cyc(1'b1, 14'h0042, 17'h1FFFF, 1'b0, 1'b0, 1'b0);
        lit("st_load", 1'b1, 14'h0042, 17'h1FFFF, 2'd1, 1'b1);
        repeat (3) begin
            cyc(1'b0, 14'h0, 17'h0, 1'b1, 1'b1, 1'b0);
            lit("st_hold", 1'b1, 14'h0042, 17'h1FFFF, 2'd1, 1'b1);
        end
        cyc(1'b0, 14'h0, 17'h0, 1'b1, 1'b0, 1'b0);
        lit("st_release", 1'b0, 14'h0000, 17'h00000, 2'd0, 1'b1);

        // Flush while FULL drops everything, including the word at the input.
        cyc(1'b1, 14'h00B1, 17'h000B1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 14'h00B2, 17'h000B2, 1'b0, 1'b0, 1'b0);
        lit("fl_full", 1'b1, 14'h00B1, 17'h000B1, 2'd2, 1'b0);
        cyc(1'b1, 14'h0077, 17'h00077, 1'b0, 1'b0, 1'b1);
        lit("fl_kill", 1'b0, 14'h0000, 17'h00000, 2'd0, 1'b1);
        cyc(1'b0, 14'h0, 17'h0, 1'b1, 1'b0, 1'b0);
        lit("fl_idle", 1'b0, 14'h0000, 17'h00000, 2'd0, 1'b1);

        // Flush wins over stall; input on that cycle is dropped.
        cyc(1'b1, 14'h00C1, 17'h000C1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 14'h00C2, 17'h000C2, 1'b1, 1'b1, 1'b1);
        lit("fl_stall", 1'b0, 14'h0000, 17'h00000, 2'd0, 1'b1);

        // Asynchronous reset between edges.
        cyc(1'b1, 14'h00D1, 17'h000D1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 14'h00D2, 17'h000D2, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 14'h00D3, 17'h000D3, 1'b0, 1'b0, 1'b0);
        lit("ar_full", 1'b1, 14'h00D1, 17'h000D1, 2'd2, 1'b0);
        rst_n = 1'b0;
        #1;
        lit("ar_async", 1'b0, 14'h0000, 17'h00000, 2'd0, 1'b1);
        #3 rst_n = 1'b1;
        #6;
        cyc(1'b1, 14'h00E1, 17'h000E1, 1'b1, 1'b0, 1'b0);
        lit("ar_first", 1'b1, 14'h00E1, 17'h000E1, 2'd1, 1'b1);
        cyc(1'b0, 14'h0, 17'h0, 1'b1, 1'b0, 1'b0);
        lit("ar_drain", 1'b0, 14'h0000, 17'h00000, 2'd0, 1'b1);

        cyc(1'b0, 14'h0, 17'h0, 1'b0, 1'b0, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
